// File: rtl/fft_stage_buf_pkg.sv
// fft_pkg: output-order encodings and the read-address permutation shared by
// the FFT stage buffer.
package fft_pkg;

    // Output order selected per frame at START
    typedef enum logic [1:0] {
        MODE_NAT     = 2'd0,
        MODE_STRIDE4 = 2'd1,
        MODE_BITREV  = 2'd2,
        MODE_RSVD    = 2'd3
    } fft_mode_e;

    // Widest supported address (LOGN up to 10)
    localparam int PERM_W = 10;

    // Address read at output position j for a frame of 2**logn samples.
    // The bit-reverse form reverses all PERM_W bits and shifts the result down,
    // which equals a logn-bit reversal because j never exceeds logn bits.
    function automatic logic [PERM_W-1:0] perm_addr(
        input logic [PERM_W-1:0] j,
        input fft_mode_e         mode,
        input int                logn
    );
        logic [PERM_W-1:0] r;
        logic [PERM_W-1:0] q_mask;
        logic [PERM_W-1:0] rev;
        q_mask = (10'd1 << (logn - 2)) - 10'd1;
        rev    = {j[0], j[1], j[2], j[3], j[4], j[5], j[6], j[7], j[8], j[9]};
        case (mode)
            MODE_STRIDE4: r = ((j & q_mask) << 2) | (j >> (logn - 2));
            MODE_BITREV:  r = rev >> (PERM_W - logn);
            default:      r = j;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_buf_if.sv
// Streaming sample interface of the FFT stage buffer: enable, frame start,
// output order, input sample and the registered output sample with RDY.
interface fft_stage_buf_if #(
    parameter int NB = 16
) ();
    logic          ED;
    logic          START;
    logic [1:0]    MODE;
    logic [NB-1:0] DR;
    logic [NB-1:0] DI;
    logic [NB-1:0] DOR;
    logic [NB-1:0] DOI;
    logic          RDY;

    modport master (
        output ED, START, MODE, DR, DI,
        input  DOR, DOI, RDY
    );

    modport slave (
        input  ED, START, MODE, DR, DI,
        output DOR, DOI, RDY
    );
endinterface

// File: rtl/fft_stage_buf_bank.sv
// fft_buf_bank: one N x W buffer bank, one write port, one read port whose
// data is held in a register that only updates on a read.
module fft_buf_bank #(
    parameter int W    = 32,
    parameter int LOGN = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [LOGN-1:0] i_waddr,
    input  logic [W-1:0]    i_wdata,
    input  logic            i_re,
    input  logic [LOGN-1:0] i_raddr,
    output logic [W-1:0]    o_rdata
);
    localparam int DEPTH = 1 << LOGN;

    logic [W-1:0] r_mem [0:DEPTH-1];
    logic [W-1:0] r_rdata;

    // Storage write; contents are not cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read data, cleared by reset and held when no read occurs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= {W{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_stage_buf.sv
// fft_stage_buf: ping-pong frame buffer that reorders a serial complex stream
// (natural / stride-4 transpose / bit-reverse). Optional sticky FRAME_ERR
// output is built when FFT_STAGE_BUF_ERR_EN is defined.
module fft_stage_buf
    import fft_pkg::*;
#(
    parameter int NB   = 16,
    parameter int LOGN = 5
) (
    input  logic          CLK,
    input  logic          RST,
    fft_stage_buf_if.slave bus
`ifdef FFT_STAGE_BUF_ERR_EN
    ,
    output logic          FRAME_ERR
`endif
);
    localparam logic [LOGN-1:0] CNT_ZERO = {LOGN{1'b0}};
    localparam logic [LOGN-1:0] CNT_ONE  = {{(LOGN-1){1'b0}}, 1'b1};
    localparam logic [LOGN-1:0] CNT_LAST = {LOGN{1'b1}};

    logic [LOGN-1:0] r_wr_cnt;
    logic            r_wr_act;
    logic            r_wr_bank;
    fft_mode_e       r_wr_mode;
    logic [LOGN-1:0] r_rd_cnt;
    logic            r_rd_act;
    logic            r_rd_bank;
    fft_mode_e       r_rd_mode;
    logic            r_out_bank;
    logic            r_rdy;

    logic            w_start;
    logic            w_wr_step;
    logic            w_wr_done;
    logic            w_rd_step;
    logic            w_we;
    logic [LOGN-1:0] w_waddr;
    logic [LOGN-1:0] w_raddr;
    logic [2*NB-1:0] w_wdata;
    logic [2*NB-1:0] w_q0;
    logic [2*NB-1:0] w_q1;
    logic [NB-1:0]   w_dor;
    logic [NB-1:0]   w_doi;
    fft_mode_e       w_start_mode;

    assign w_start   = bus.ED & bus.START;
    assign w_wr_step = bus.ED & ~bus.START & r_wr_act;
    assign w_wr_done = w_wr_step & (r_wr_cnt == CNT_LAST);
    assign w_rd_step = bus.ED & r_rd_act;
    assign w_we      = w_start | w_wr_step;
    assign w_waddr   = w_start ? CNT_ZERO : r_wr_cnt;
    assign w_wdata   = {bus.DR, bus.DI};
    assign w_raddr   = LOGN'(perm_addr(PERM_W'(r_rd_cnt), r_rd_mode, LOGN));

    // Decode MODE at START; the reserved code reads out in natural order
    always_comb begin
        w_start_mode = MODE_NAT;
        case (bus.MODE)
            2'd1:    w_start_mode = MODE_STRIDE4;
            2'd2:    w_start_mode = MODE_BITREV;
            default: w_start_mode = MODE_NAT;
        endcase
    end

    // Write side: START (even mid-frame) restarts at address 0 of the current
    // bank; the last address hands the bank over to the reader
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_wr_cnt  <= CNT_ZERO;
            r_wr_act  <= 1'b0;
            r_wr_bank <= 1'b0;
            r_wr_mode <= MODE_NAT;
        end else if (w_start) begin
            r_wr_cnt  <= CNT_ONE;
            r_wr_act  <= 1'b1;
            r_wr_mode <= w_start_mode;
        end else if (w_wr_done) begin
            r_wr_cnt  <= CNT_ZERO;
            r_wr_act  <= 1'b0;
            r_wr_bank <= ~r_wr_bank;
        end else if (w_wr_step) begin
            r_wr_cnt  <= r_wr_cnt + CNT_ONE;
        end
    end

    // Read side: a completed bank (with its latched mode) is read for N
    // enabled cycles; a new hand-over takes priority over the final step
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_rd_cnt  <= CNT_ZERO;
            r_rd_act  <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_mode <= MODE_NAT;
        end else if (w_wr_done) begin
            r_rd_cnt  <= CNT_ZERO;
            r_rd_act  <= 1'b1;
            r_rd_bank <= r_wr_bank;
            r_rd_mode <= r_wr_mode;
        end else if (w_rd_step) begin
            if (r_rd_cnt == CNT_LAST) begin
                r_rd_cnt <= CNT_ZERO;
                r_rd_act <= 1'b0;
            end else begin
                r_rd_cnt <= r_rd_cnt + CNT_ONE;
            end
        end
    end

    // RDY marks output sample 0; the output bank select follows the reads
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_rdy      <= 1'b0;
            r_out_bank <= 1'b0;
        end else if (bus.ED) begin
            r_rdy <= r_rd_act & (r_rd_cnt == CNT_ZERO);
            if (r_rd_act) begin
                r_out_bank <= r_rd_bank;
            end
        end
    end

    fft_buf_bank #(.W(2*NB), .LOGN(LOGN)) u_bank0 (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_we    (w_we & ~r_wr_bank),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_step & ~r_rd_bank),
        .i_raddr (w_raddr),
        .o_rdata (w_q0)
    );

    fft_buf_bank #(.W(2*NB), .LOGN(LOGN)) u_bank1 (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_we    (w_we & r_wr_bank),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_step & r_rd_bank),
        .i_raddr (w_raddr),
        .o_rdata (w_q1)
    );

    // Select the registered read data of the bank that was read last
    always_comb begin
        if (r_out_bank) begin
            w_dor = w_q1[2*NB-1:NB];
            w_doi = w_q1[NB-1:0];
        end else begin
            w_dor = w_q0[2*NB-1:NB];
            w_doi = w_q0[NB-1:0];
        end
    end

    assign bus.DOR = w_dor;
    assign bus.DOI = w_doi;
    assign bus.RDY = r_rdy;

`ifdef FFT_STAGE_BUF_ERR_EN
    logic r_frame_err;

    // Sticky flag for a START that abandons a partial frame or uses MODE 3
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_frame_err <= 1'b0;
        end else if (w_start && (r_wr_act || (bus.MODE == 2'd3))) begin
            r_frame_err <= 1'b1;
        end
    end

    assign FRAME_ERR = r_frame_err;
`endif
endmodule

// File: tb/tb_fft_stage_buf.sv
// Scoreboard bench for fft_stage_buf (N = 32): directed frames push their
// expected output samples; a negedge monitor pops and compares them.
module tb_fft_stage_buf;
    localparam int NB   = 16;
    localparam int LOGN = 5;
    localparam int N    = 32;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    fft_stage_buf_if #(.NB(NB)) bus ();
`ifdef FFT_STAGE_BUF_ERR_EN
    logic frame_err;
`endif

    fft_stage_buf #(.NB(NB), .LOGN(LOGN)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef FFT_STAGE_BUF_ERR_EN
        ,
        .FRAME_ERR (frame_err)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] dr;
        logic [15:0] di;
        bit          first;
        int          en_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks    = 0;
    int          errors    = 0;
    int          en_cnt    = 0;
    bit          last_en   = 1'b0;
    int          remaining = 0;
    logic [15:0] last_dor  = 16'd0;
    logic [15:0] last_doi  = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference output order, written independently of the RTL
    function automatic int tb_perm(input int mode, input int j);
        int r;
        case (mode)
            1: r = (j % (N / 4)) * 4 + j / (N / 4);
            2: begin
                r = 0;
                for (int k = 0; k < LOGN; k++) r = r * 2 + ((j >> k) & 1);
            end
            default: r = j;
        endcase
        return r;
    endfunction

    // Count enabled, non-reset edges
    always @(posedge CLK) begin
        last_en = bus.ED && RST;
        if (last_en) en_cnt++;
    end

    // Monitor: compare outputs after each enabled edge
    always @(negedge CLK) begin
        if (last_en) begin
            if (bus.RDY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rdy_unexpected", {31'd0, bus.RDY}, 32'd0);
                    remaining = 0;
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rdy_pos", {31'd0, bus.RDY}, {31'd0, mon_e.first});
                    chk("rdy_time", en_cnt, mon_e.en_cyc);
                    chk("dor", {16'd0, bus.DOR}, {16'd0, mon_e.dr});
                    chk("doi", {16'd0, bus.DOI}, {16'd0, mon_e.di});
                    last_dor  = mon_e.dr;
                    last_doi  = mon_e.di;
                    remaining = N - 1;
                end
            end else if (remaining > 0 && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("rdy_low", {31'd0, bus.RDY}, 32'd0);
                chk("smp_time", en_cnt, mon_e.en_cyc);
                chk("dor", {16'd0, bus.DOR}, {16'd0, mon_e.dr});
                chk("doi", {16'd0, bus.DOI}, {16'd0, mon_e.di});
                last_dor = mon_e.dr;
                last_doi = mon_e.di;
                remaining--;
            end else begin
                remaining = 0;
                chk("hold_dor", {16'd0, bus.DOR}, {16'd0, last_dor});
                chk("hold_doi", {16'd0, bus.DOI}, {16'd0, last_doi});
            end
        end
        if (RST === 1'b0) begin
            exp_q.delete();
            remaining = 0;
            last_dor  = 16'd0;
            last_doi  = 16'd0;
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
            bus.ED    = 1'b1;
            bus.START = 1'b0;
            bus.MODE  = 2'(k);
            bus.DR    = 16'($urandom);
            bus.DI    = 16'($urandom);
        end
    endtask

    // Send len samples from START; a complete frame pushes its expected output
    task automatic send_frame(input logic [1:0] mode, input int base, input bit di_zero,
                              input bit toggle, input int len);
        logic [15:0] dr_a [N];
        logic [15:0] di_a [N];
        int   i;
        int   s;
        int   p;
        bit   ph;
        exp_t e;
        i = 0; s = 0; ph = 1'b0;
        while (i < len) begin
            @(posedge CLK); #1;
            if (toggle && ph) begin
                bus.ED    = 1'b0;
                bus.START = 1'b0;
                bus.DR    = 16'hDEAD;
                bus.DI    = 16'hBEEF;
            end else begin
                bus.ED    = 1'b1;
                bus.START = (i == 0);
                bus.MODE  = (i == 0) ? mode : ~mode;
                dr_a[i]   = 16'(base + i);
                di_a[i]   = di_zero ? 16'd0 : (16'(base + i) ^ 16'h5A5A);
                bus.DR    = dr_a[i];
                bus.DI    = di_a[i];
                if (i == 0) s = en_cnt + 1;
                i++;
            end
            if (toggle) ph = ~ph;
        end
        if (len == N) begin
            for (int j = 0; j < N; j++) begin
                p        = tb_perm(int'(mode), j);
                e.dr     = dr_a[p];
                e.di     = di_a[p];
                e.first  = (j == 0);
                e.en_cyc = s + N + j;
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        int w;
        bus.ED = 1'b0; bus.START = 1'b0; bus.MODE = 2'd0; bus.DR = 16'd0; bus.DI = 16'd0;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_dor", {16'd0, bus.DOR}, 32'd0);
        chk("reset_doi", {16'd0, bus.DOI}, 32'd0);
        chk("reset_rdy", {31'd0, bus.RDY}, 32'd0);
`ifdef FFT_STAGE_BUF_ERR_EN
        chk("reset_err", {31'd0, frame_err}, 32'd0);
`endif
        RST = 1'b1;

        // Natural order, DR = index, DI = 0
        send_frame(2'd0, 0, 1'b1, 1'b0, N);
        idle(40);
        // Bit-reverse order
        send_frame(2'd2, 0, 1'b0, 1'b0, N);
        idle(40);
        // Stride-4 frame immediately followed by a natural frame
        send_frame(2'd1, 0, 1'b0, 1'b0, N);
        send_frame(2'd0, 100, 1'b0, 1'b0, N);
        idle(70);
        // ED toggling throughout a natural frame
        send_frame(2'd0, 200, 1'b0, 1'b1, N);
        idle(80);
`ifdef FFT_STAGE_BUF_ERR_EN
        chk("err_clean", {31'd0, frame_err}, 32'd0);
`endif
        // Full frame, then a frame restarted at sample 10, then the restart
        send_frame(2'd0, 300, 1'b0, 1'b0, N);
        send_frame(2'd0, 400, 1'b0, 1'b0, 10);
        send_frame(2'd2, 500, 1'b0, 1'b0, N);
        idle(80);
`ifdef FFT_STAGE_BUF_ERR_EN
        chk("err_set", {31'd0, frame_err}, 32'd1);
`endif
        // Reserved mode reads out naturally
        send_frame(2'd3, 600, 1'b0, 1'b0, N);
        idle(40);

        // Reset at output sample 5
        send_frame(2'd0, 700, 1'b0, 1'b0, N);
        w = 0;
        while (bus.RDY !== 1'b1 && w < 100) begin
            @(posedge CLK); #1;
            w++;
        end
        if (w >= 100) chk("rdy_timeout", {31'd0, bus.RDY}, 32'd1);
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("rst_dor", {16'd0, bus.DOR}, 32'd0);
        chk("rst_doi", {16'd0, bus.DOI}, 32'd0);
        chk("rst_rdy", {31'd0, bus.RDY}, 32'd0);
`ifdef FFT_STAGE_BUF_ERR_EN
        chk("rst_err", {31'd0, frame_err}, 32'd0);
`endif
        @(posedge CLK); #1;
        RST = 1'b1;
        idle(40);

        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge CLK);
            w++;
        end
        if (exp_q.size() != 0) chk("drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_stage_buf.md
FFT_STAGE_BUF -- requirements
Module: fft_stage_buf

Interface
REQ-001 Parameter NB, default 16: bit width of each real and each imaginary sample.
REQ-002 Parameter LOGN, default 5: log2 of frame length N; legal range 2..10.
REQ-003 CLK  input  1: sole clock; all state updates on its rising edge.
REQ-004 RST  input  1: reset, synchronous, active-low.
REQ-005 ED  input  1: clock enable; 0 freezes all counters, bank state and output registers.
REQ-006 START  input  1: pulse marking sample 0 of an input frame; DR/DI are valid in the same cycle.
REQ-007 MODE  input  2: output order for the frame, sampled with START; 0 natural, 1 stride-4 transpose, 2 bit-reverse, 3 reserved (treated as natural).
REQ-008 DR, DI  input  NB each: serial input sample, real and imaginary parts.
REQ-009 DOR, DOI  output  NB each: registered serial output sample.
REQ-010 RDY  output  1: one-cycle pulse coincident with output sample 0 of a frame.

Function
REQ-011 Buffer SHALL be ping-pong: two banks of N complex words; one bank is written while the other is read.
REQ-012 Input samples SHALL be written in natural order, one per ED cycle, into address 0..N-1 of the write bank, counting from START.
REQ-013 After address N-1 is written, banks SHALL swap, and the filled bank SHALL be read one address per ED cycle for N cycles.
REQ-014 Output position j SHALL read address perm(j): natural perm(j)=j; stride-4 perm(j)=4*(j mod N/4)+(j div N/4); bit-reverse perm(j)=LOGN-bit reversal of j.
REQ-015 Latency: with START in cycle 0 and ED held at 1, RDY and output sample 0 SHALL appear in cycle N+1; sample j SHALL appear in cycle N+1+j.
REQ-016 Back-to-back frames (next START in cycle N) SHALL stream gap-free; RDY SHALL repeat every N cycles.
REQ-017 With no further START, the write counter SHALL idle and the pending read SHALL still complete.
REQ-018 MODE SHALL be latched per frame at START and travel with that frame's bank; changing MODE mid-frame SHALL have no effect.
REQ-019 START while a frame is partly written SHALL abandon the partial frame and restart writing at address 0 of the same bank; the read of a previously completed frame SHALL continue undisturbed.
REQ-020 Between frames, outside the read window, DOR/DOI SHALL hold their last value and RDY SHALL be 0.

Reset
REQ-021 While RST=0 at a clock edge: DOR=0, DOI=0, RDY=0, counters=0, write bank=0, no read pending, latched modes=0.
REQ-022 Reset mid-frame SHALL discard all in-flight data; RAM contents need not be cleared.

Configuration
REQ-023 Macro FFT_STAGE_BUF_ERR_EN: when defined, output FRAME_ERR (1 bit) SHALL exist; it is set sticky on a REQ-019 mid-frame START or on a MODE=3 START, and cleared only by reset.
REQ-024 Without FFT_STAGE_BUF_ERR_EN, port FRAME_ERR and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 The shared package fft_pkg SHALL hold the MODE encodings (MODE_NAT, MODE_STRIDE4, MODE_BITREV) and the permutation function used for perm(j).
REQ-026 Each bank SHALL be one instance of sub-module fft_buf_bank: N x 2*NB, one write port, one read port with registered read data.

Verification
REQ-027 N=32, MODE=0, DR=index 0..31, DI=0: DOR=0..31 in cycles 33..64; RDY is high only in cycle 33.
REQ-028 N=32, MODE=2, DR=index: DOR sequence 0,16,8,24,4,20,12,28,... through 31.
REQ-029 N=32, MODE=1, DR=index, immediately followed by a MODE=0 frame: first output sequence 0,4,...,28,1,5,...,31; then 0..31 with no gap; RDY in cycles 33 and 65.
REQ-030 ED is toggled 1,0,1,0 throughout a MODE=0 frame: output order is unchanged and RDY appears in the 33rd enabled cycle after START.
REQ-031 START is re-asserted at input sample 10 with FFT_STAGE_BUF_ERR_EN defined: only the restarted frame is output, and FRAME_ERR=1 is held until RST=0.
REQ-032 RST=0 is asserted at output sample 5: in the next cycle DOR=0 and RDY=0, and no further outputs appear until a new START.
